// File: rtl/rev_exec_ctrl_if.sv
// Bundle of retire-time events and direction-control outputs exchanged between
// the ALU retire stage (master) and the direction controller (slave).
interface rev_exec_ctrl_if #(
    parameter int PC_W  = 16,
    parameter int SIG_W = 4
);
    logic             ev_jerr;
    logic             ev_fail;
    logic             ev_com;
    logic             ev_sys;
    logic [SIG_W-1:0] ev_mask;
    logic [PC_W-1:0]  ev_target;
    logic             retire;
    logic             fwd;
    logic             flush;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic [SIG_W-1:0] check;
    logic [SIG_W-1:0] errors;
    logic             halt;
    logic [1:0]       halt_cause;

    modport master (
        output ev_jerr, ev_fail, ev_com, ev_sys, ev_mask, ev_target, retire,
        input  fwd, flush, redirect_valid, redirect_pc, check, errors, halt, halt_cause
    );

    modport slave (
        input  ev_jerr, ev_fail, ev_com, ev_sys, ev_mask, ev_target, retire,
        output fwd, flush, redirect_valid, redirect_pc, check, errors, halt, halt_cause
    );
endinterface

// File: rtl/rev_exec_ctrl.sv
// AXA pipeline direction controller: forward/reverse mode, signal masks, flush
// sequencing, rollback redirect and halt. REV_WDOG_EN adds a reverse-mode retire watchdog.
module rev_exec_ctrl #(
    parameter int FLUSH_CYCLES = 4,
    parameter int PC_W         = 16,
    parameter int SIG_W        = 4,
    parameter int WDOG_LIMIT   = 256
) (
    input  logic               clk,
    input  logic               reset,
    rev_exec_ctrl_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_FWD   = 2'd0,
        ST_REV   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              pend_fwd_q, pend_fwd_d;
    logic [3:0]        flush_cnt_q, flush_cnt_d;
    logic              fwd_q, fwd_d;
    logic              flush_q, flush_d;
    logic              rv_q, rv_d;
    logic [PC_W-1:0]   rpc_q, rpc_d;
    logic [SIG_W-1:0]  check_q, check_d;
    logic [SIG_W-1:0]  errors_q, errors_d;
    logic              halt_q, halt_d;
    logic [1:0]        cause_q, cause_d;
    logic [SIG_W-1:0]  err_left_s;

`ifdef REV_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_LIMIT) + 1;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
`else
    logic              unused_s;
    assign unused_s = bus.retire | (WDOG_LIMIT < 1);
`endif

    assign err_left_s = errors_q & ~bus.ev_mask;

    // Next-state and next-output decode; only the highest-priority event acts.
    always_comb begin
        state_d     = state_q;
        pend_fwd_d  = pend_fwd_q;
        flush_cnt_d = flush_cnt_q;
        fwd_d       = fwd_q;
        flush_d     = 1'b0;
        rv_d        = 1'b0;
        rpc_d       = rpc_q;
        check_d     = check_q;
        errors_d    = errors_q;
        halt_d      = halt_q;
        cause_d     = cause_q;
`ifdef REV_WDOG_EN
        wdog_d      = wdog_q;
`endif
        case (state_q)
            ST_FWD: begin
                if (bus.ev_sys) begin
                    state_d = ST_HALT;
                    halt_d  = 1'b1;
                    flush_d = 1'b1;
                    cause_d = 2'd1;
                end else if (bus.ev_fail) begin
                    if ((bus.ev_mask & ~check_q) != '0) begin
                        state_d = ST_HALT;
                        halt_d  = 1'b1;
                        flush_d = 1'b1;
                        cause_d = 2'd2;
                    end else begin
                        errors_d    = bus.ev_mask & check_q;
                        state_d     = ST_FLUSH;
                        pend_fwd_d  = 1'b0;
                        fwd_d       = 1'b0;
                        flush_d     = 1'b1;
                        flush_cnt_d = 4'(FLUSH_CYCLES - 1);
                    end
                end else if (bus.ev_jerr) begin
                    check_d = check_q | bus.ev_mask;
                end else if (bus.ev_com) begin
                    check_d = '0;
                end else begin
                    check_d = check_q;
                end
            end
            ST_REV: begin
                if (bus.ev_sys) begin
                    state_d = ST_HALT;
                    halt_d  = 1'b1;
                    flush_d = 1'b1;
                    cause_d = 2'd1;
                end else if (bus.ev_jerr) begin
                    errors_d = err_left_s;
                    check_d  = check_q & ~bus.ev_mask;
                    // Last outstanding error cleared: rollback is done, resume forward.
                    if (err_left_s == '0) begin
                        rpc_d       = bus.ev_target;
                        rv_d        = 1'b1;
                        state_d     = ST_FLUSH;
                        pend_fwd_d  = 1'b1;
                        fwd_d       = 1'b1;
                        flush_d     = 1'b1;
                        flush_cnt_d = 4'(FLUSH_CYCLES - 1);
                    end else begin
                        state_d = ST_REV;
                    end
                end else if (bus.ev_com) begin
                    errors_d = '0;
                end else begin
                    errors_d = errors_q;
                end
`ifdef REV_WDOG_EN
                if ((state_d == ST_REV) && bus.retire) begin
                    wdog_d = wdog_q + WDOG_W'(1);
                    if (wdog_d == WDOG_W'(WDOG_LIMIT)) begin
                        state_d = ST_HALT;
                        halt_d  = 1'b1;
                        flush_d = 1'b1;
                        cause_d = 2'd3;
                    end else begin
                        halt_d  = halt_q;
                    end
                end else begin
                    wdog_d = wdog_q;
                end
`endif
            end
            ST_FLUSH: begin
                if (bus.ev_sys) begin
                    state_d = ST_HALT;
                    halt_d  = 1'b1;
                    flush_d = 1'b1;
                    cause_d = 2'd1;
                end else if (flush_cnt_q == 4'd0) begin
                    state_d = pend_fwd_q ? ST_FWD : ST_REV;
`ifdef REV_WDOG_EN
                    wdog_d  = '0;
`endif
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                    flush_d     = 1'b1;
                end
            end
            ST_HALT: begin
                flush_d = 1'b1;
                halt_d  = 1'b1;
            end
            default: begin
                state_d = ST_HALT;
                flush_d = 1'b1;
                halt_d  = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FWD;
            pend_fwd_q  <= 1'b1;
            flush_cnt_q <= 4'd0;
            fwd_q       <= 1'b1;
            flush_q     <= 1'b0;
            rv_q        <= 1'b0;
            rpc_q       <= '0;
            check_q     <= '0;
            errors_q    <= '0;
            halt_q      <= 1'b0;
            cause_q     <= 2'd0;
`ifdef REV_WDOG_EN
            wdog_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pend_fwd_q  <= pend_fwd_d;
            flush_cnt_q <= flush_cnt_d;
            fwd_q       <= fwd_d;
            flush_q     <= flush_d;
            rv_q        <= rv_d;
            rpc_q       <= rpc_d;
            check_q     <= check_d;
            errors_q    <= errors_d;
            halt_q      <= halt_d;
            cause_q     <= cause_d;
`ifdef REV_WDOG_EN
            wdog_q      <= wdog_d;
`endif
        end
    end

    assign bus.fwd            = fwd_q;
    assign bus.flush          = flush_q;
    assign bus.redirect_valid = rv_q;
    assign bus.redirect_pc    = rpc_q;
    assign bus.check          = check_q;
    assign bus.errors         = errors_q;
    assign bus.halt           = halt_q;
    assign bus.halt_cause     = cause_q;

endmodule

// File: tb/tb_rev_exec_ctrl.sv
// Self-checking bench for rev_exec_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_rev_exec_ctrl;

    localparam int FC = 4;
    localparam int PW = 16;
    localparam int SW = 4;
    localparam int WL = 8;

    localparam int MD_FWD   = 0;
    localparam int MD_REV   = 1;
    localparam int MD_FLUSH = 2;
    localparam int MD_HALT  = 3;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    rev_exec_ctrl_if #(.PC_W(PW), .SIG_W(SW)) bus ();

    rev_exec_ctrl #(
        .FLUSH_CYCLES(FC),
        .PC_W(PW),
        .SIG_W(SW),
        .WDOG_LIMIT(WL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, sys, fail, jerr, com;
        logic [3:0]  mask;
        logic [15:0] tgt;
        logic        ret;
        logic [29:0] exp;
    } vec_t;

    vec_t vecs[$];

    // behavioural model state
    int          m_mode;
    int          m_left;
    bit          m_pend_fwd;
    int          m_retires;
    bit          m_fwd, m_flush, m_rv, m_halt;
    logic [15:0] m_rpc;
    logic [3:0]  m_check, m_errors;
    logic [1:0]  m_cause;

    function automatic logic [29:0] pk(input logic f, input logic fl, input logic rv,
                                       input logic [15:0] rpc, input logic [3:0] c,
                                       input logic [3:0] e, input logic h, input logic [1:0] hc);
        return {f, fl, rv, rpc, c, e, h, hc};
    endfunction

    function automatic vec_t mk(input logic rst, input logic sys, input logic fail,
                                input logic jerr, input logic com, input logic [3:0] mask,
                                input logic [15:0] tgt, input logic [29:0] exp);
        vec_t v;
        v.rst = rst; v.sys = sys; v.fail = fail; v.jerr = jerr; v.com = com;
        v.mask = mask; v.tgt = tgt; v.ret = 1'b0; v.exp = exp;
        return v;
    endfunction

    function automatic logic [29:0] actual();
        return {bus.fwd, bus.flush, bus.redirect_valid, bus.redirect_pc,
                bus.check, bus.errors, bus.halt, bus.halt_cause};
    endfunction

    task automatic drive(input logic rst, input logic sys, input logic fail, input logic jerr,
                         input logic com, input logic [3:0] mask, input logic [15:0] tgt,
                         input logic ret);
        reset = rst; bus.ev_sys = sys; bus.ev_fail = fail; bus.ev_jerr = jerr;
        bus.ev_com = com; bus.ev_mask = mask; bus.ev_target = tgt; bus.retire = ret;
    endtask

    task automatic compare(input string name, input logic [29:0] act, input logic [29:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %b expected %b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = MD_FWD; m_left = 0; m_pend_fwd = 1'b1; m_retires = 0;
        m_fwd = 1'b1; m_flush = 1'b0; m_rv = 1'b0; m_halt = 1'b0;
        m_rpc = '0; m_check = '0; m_errors = '0; m_cause = 2'd0;
    endtask

    task automatic m_go_halt(input logic [1:0] c);
        m_mode = MD_HALT; m_halt = 1'b1; m_flush = 1'b1; m_cause = c;
    endtask

    task automatic m_start_flush(input bit to_fwd);
        m_mode = MD_FLUSH; m_pend_fwd = to_fwd; m_fwd = to_fwd; m_flush = 1'b1; m_left = FC;
    endtask

    // Applies the controller rules to the inputs currently presented.
    task automatic model_step();
        logic [3:0] mk_v;
        mk_v = bus.ev_mask;
        if (reset) begin
            model_reset();
        end else begin
            m_rv = 1'b0;
            case (m_mode)
                MD_HALT: m_flush = 1'b1;
                MD_FLUSH: begin
                    if (bus.ev_sys) m_go_halt(2'd1);
                    else begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            m_flush = 1'b0;
                            m_mode = m_pend_fwd ? MD_FWD : MD_REV;
                            m_retires = 0;
                        end else m_flush = 1'b1;
                    end
                end
                MD_FWD: begin
                    m_flush = 1'b0;
                    if (bus.ev_sys) m_go_halt(2'd1);
                    else if (bus.ev_fail) begin
                        if ((mk_v & ~m_check) != 4'd0) m_go_halt(2'd2);
                        else begin
                            m_errors = mk_v & m_check;
                            m_start_flush(1'b0);
                        end
                    end else if (bus.ev_jerr) m_check = m_check | mk_v;
                    else if (bus.ev_com) m_check = 4'd0;
                end
                MD_REV: begin
                    m_flush = 1'b0;
                    if (bus.ev_sys) m_go_halt(2'd1);
                    else if (bus.ev_jerr && ((m_errors & ~mk_v) == 4'd0)) begin
                        m_errors = 4'd0;
                        m_check = m_check & ~mk_v;
                        m_rpc = bus.ev_target;
                        m_rv = 1'b1;
                        m_start_flush(1'b1);
                    end else begin
                        if (bus.ev_jerr) begin
                            m_errors = m_errors & ~mk_v;
                            m_check = m_check & ~mk_v;
                        end else if (bus.ev_com) m_errors = 4'd0;
`ifdef REV_WDOG_EN
                        if (bus.retire) begin
                            m_retires = m_retires + 1;
                            if (m_retires >= WL) m_go_halt(2'd3);
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(input string name);
        model_step();
        @(posedge clk);
        #1;
        compare(name, actual(), pk(m_fwd, m_flush, m_rv, m_rpc, m_check, m_errors, m_halt, m_cause));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        drive(1'b1, 0, 0, 0, 0, 4'd0, 16'd0, 1'b0);

        // Directed table: reversal, rollback completion, unhandled fail, priority.
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'h0, 16'h0000, pk(1, 0, 0, 16'h0000, 4'h0, 4'h0, 0, 2'd0)));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'h5, 16'h0000, pk(1, 0, 0, 16'h0000, 4'h5, 4'h0, 0, 2'd0)));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'h5, 16'h0000, pk(0, 1, 0, 16'h0000, 4'h5, 4'h5, 0, 2'd0)));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 4'h0, 16'h0000, pk(0, 1, 0, 16'h0000, 4'h5, 4'h5, 0, 2'd0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'h0, 16'h0000, pk(0, 0, 0, 16'h0000, 4'h5, 4'h5, 0, 2'd0)));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'h1, 16'h0099, pk(0, 0, 0, 16'h0000, 4'h4, 4'h4, 0, 2'd0)));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'h4, 16'h0012, pk(1, 1, 1, 16'h0012, 4'h0, 4'h0, 0, 2'd0)));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 4'h0, 16'h0000, pk(1, 1, 0, 16'h0012, 4'h0, 4'h0, 0, 2'd0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'h0, 16'h0000, pk(1, 0, 0, 16'h0012, 4'h0, 4'h0, 0, 2'd0)));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'h4, 16'h0000, pk(1, 0, 0, 16'h0012, 4'h4, 4'h0, 0, 2'd0)));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'h3, 16'h0000, pk(1, 1, 0, 16'h0012, 4'h4, 4'h0, 1, 2'd2)));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'hF, 16'h1234, pk(1, 1, 0, 16'h0012, 4'h4, 4'h0, 1, 2'd2)));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0, 16'h0000, pk(1, 1, 0, 16'h0012, 4'h4, 4'h0, 1, 2'd2)));
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'h0, 16'h0000, pk(1, 0, 0, 16'h0000, 4'h0, 4'h0, 0, 2'd0)));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'h5, 16'h0000, pk(1, 1, 0, 16'h0000, 4'h0, 4'h0, 1, 2'd1)));
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'h0, 16'h0000, pk(1, 0, 0, 16'h0000, 4'h0, 4'h0, 0, 2'd0)));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'h4, 16'h0000, pk(1, 0, 0, 16'h0000, 4'h4, 4'h0, 0, 2'd0)));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'h4, 16'h0000, pk(0, 1, 0, 16'h0000, 4'h4, 4'h4, 0, 2'd0)));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 4'h0, 16'h0000, pk(0, 1, 0, 16'h0000, 4'h4, 4'h4, 0, 2'd0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'h0, 16'h0000, pk(0, 0, 0, 16'h0000, 4'h4, 4'h4, 0, 2'd0)));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].sys, vecs[i].fail, vecs[i].jerr, vecs[i].com,
                  vecs[i].mask, vecs[i].tgt, vecs[i].ret);
            @(posedge clk);
            #1;
            compare($sformatf("vec%0d", i), actual(), vecs[i].exp);
        end

        // com in REV clears errors, then a jerr with empty mask completes the rollback.
        model_reset();
        drive(1, 0, 0, 0, 0, 4'h0, 16'h0, 0); step("comseq_rst");
        drive(0, 0, 0, 1, 0, 4'h3, 16'h0, 0); step("comseq_jerr");
        drive(0, 0, 1, 0, 0, 4'h3, 16'h0, 0); step("comseq_fail");
        drive(0, 0, 0, 0, 0, 4'h0, 16'h0, 0);
        for (int i = 0; i < FC; i++) step("comseq_flush");
        drive(0, 0, 0, 0, 1, 4'h0, 16'h0, 0); step("comseq_com");
        cmp1("comseq_errors_zero", bus.errors == 4'h0, 1'b1);
        drive(0, 0, 0, 1, 0, 4'h0, 16'h0ABC, 0); step("comseq_jerr0");
        cmp1("comseq_redirect", bus.redirect_valid, 1'b1);
        cmp1("comseq_rpc", bus.redirect_pc == 16'h0ABC, 1'b1);

        // Reset asserted during the second flush cycle.
        drive(1, 0, 0, 0, 0, 4'h0, 16'h0, 0); step("rstflush_rst");
        drive(0, 0, 0, 1, 0, 4'h2, 16'h0, 0); step("rstflush_jerr");
        drive(0, 0, 1, 0, 0, 4'h2, 16'h0, 0); step("rstflush_fail");
        drive(0, 0, 0, 0, 0, 4'h0, 16'h0, 0); step("rstflush_f2");
        drive(1, 0, 0, 1, 0, 4'h2, 16'h0, 0); step("rstflush_reset");
        cmp1("rstflush_fwd", bus.fwd, 1'b1);
        cmp1("rstflush_flush", bus.flush, 1'b0);
        cmp1("rstflush_rv", bus.redirect_valid, 1'b0);
        drive(0, 0, 0, 0, 0, 4'h0, 16'h0, 0); step("rstflush_after");
        cmp1("rstflush_rv_after", bus.redirect_valid, 1'b0);

        // Reverse-mode retire budget.
        drive(1, 0, 0, 0, 0, 4'h0, 16'h0, 0); step("wdog_rst");
        drive(0, 0, 0, 1, 0, 4'h1, 16'h0, 0); step("wdog_jerr");
        drive(0, 0, 1, 0, 0, 4'h1, 16'h0, 0); step("wdog_fail");
        drive(0, 0, 0, 0, 0, 4'h0, 16'h0, 0);
        for (int i = 0; i < FC; i++) step("wdog_flush");
        drive(0, 0, 0, 0, 0, 4'h0, 16'h0, 1);
        for (int i = 0; i < WL; i++) step("wdog_retire");
`ifdef REV_WDOG_EN
        cmp1("wdog_halt", bus.halt, 1'b1);
        cmp1("wdog_cause3", bus.halt_cause == 2'd3, 1'b1);
`else
        cmp1("wdog_nohalt", bus.halt, 1'b0);
        cmp1("wdog_still_rev", bus.fwd, 1'b0);
`endif

        // Randomized traffic against the model.
        drive(1, 0, 0, 0, 0, 4'h0, 16'h0, 0); step("rnd_rst");
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 149) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)),
                  16'($urandom_range(0, 65535)), ($urandom_range(0, 1) == 1));
            step($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
